// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for the single-port data RAM.
// The CPU memory-access stage has priority. The host/debug port gets a
// one-cycle acknowledge after each grant.
// Optional feature macro: DMEM_ARB_STARVE_EN. When it is defined, a
// starvation counter forces a host grant after STARVE_MAX lost cycles.
module dmem_arbiter #(
    parameter int unsigned ADR_W      = 12,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // CPU memory-access stage
    input  logic             cpu_req,
    input  logic [3:0]       cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    // host/debug monitor
    input  logic             host_req,
    input  logic [3:0]       host_we,
    input  logic [ADR_W-1:0] host_adr,
    input  logic [31:0]      host_wdata,
    output logic             host_ack,
    output logic [31:0]      host_rdata,
    // data RAM macro
    output logic [ADR_W-1:0] ram_adr,
    output logic [3:0]       ram_we,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } hstate_t;

    // Reject an out-of-range starvation limit at elaboration time
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dmem_arbiter: STARVE_MAX must be in 1..15");
    end

    hstate_t          hstate;
    logic             host_grant;
    logic             cpu_grant;
    logic             host_eligible;
    logic [ADR_W-1:0] adr_q;
    logic [31:0]      wdata_q;

    assign host_eligible = host_req && (hstate == H_IDLE);

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Host wins when the CPU is idle or the host has starved long enough
    always_comb begin
        host_grant = rst_n && host_eligible && (!cpu_req || starve_hit);
        cpu_grant  = rst_n && cpu_req && !host_grant;
        cpu_stall  = rst_n && cpu_req && !cpu_grant;
    end

    // Count consecutive cycles an eligible host loses to the CPU; saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (host_grant || !host_req) begin
            starve_cnt <= 4'd0;
        end else if (host_eligible && cpu_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    // Strict CPU priority: the host only gets cycles the CPU leaves free
    always_comb begin
        host_grant = rst_n && host_eligible && !cpu_req;
        cpu_grant  = rst_n && cpu_req && !host_grant;
        cpu_stall  = 1'b0;
    end
`endif

    // RAM pin mux; with no grant the address/data hold and writes are off
    always_comb begin
        ram_adr   = adr_q;
        ram_wdata = wdata_q;
        ram_we    = 4'd0;
        if (host_grant) begin
            ram_adr   = host_adr;
            ram_wdata = host_wdata;
            ram_we    = host_we;
        end else if (cpu_grant) begin
            ram_adr   = cpu_adr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
        end
    end

    // Remember the last driven address/data for cycles without a grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adr_q   <= '0;
            wdata_q <= 32'd0;
        end else begin
            adr_q   <= ram_adr;
            wdata_q <= ram_wdata;
        end
    end

    // Host handshake FSM: a grant is always followed by one acknowledge cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hstate   <= H_IDLE;
            host_ack <= 1'b0;
        end else begin
            case (hstate)
                H_IDLE: begin
                    if (host_grant) begin
                        hstate   <= H_ACK;
                        host_ack <= 1'b1;
                    end else begin
                        hstate   <= H_IDLE;
                        host_ack <= 1'b0;
                    end
                end
                H_ACK: begin
                    hstate   <= H_IDLE;
                    host_ack <= 1'b0;
                end
                default: begin
                    hstate   <= H_IDLE;
                    host_ack <= 1'b0;
                end
            endcase
        end
    end

    // Read data: the RAM output is shared; the host copy is qualified by the ack
    always_comb begin
        cpu_rdata  = ram_rdata;
        host_rdata = host_ack ? ram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural byte-write RAM.
// The contention section picks its expected values from DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

    localparam int unsigned ADR_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cpu_req;
    logic [3:0]       cpu_we;
    logic [ADR_W-1:0] cpu_adr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_stall;
    logic             host_req;
    logic [3:0]       host_we;
    logic [ADR_W-1:0] host_adr;
    logic [31:0]      host_wdata;
    logic             host_ack;
    logic [31:0]      host_rdata;
    logic [ADR_W-1:0] ram_adr;
    logic [3:0]       ram_we;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    logic [31:0] mem [0:4095];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADR_W      (ADR_W),
        .STARVE_MAX (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_adr    (cpu_adr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_adr   (host_adr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .ram_adr    (ram_adr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous RAM: byte-lane writes, 1-cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_adr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (still before negedge)
    task automatic settle();
        #3;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".host_ack"},   32'(host_ack),   32'd0);
        check({tag, ".host_rdata"}, host_rdata,      32'd0);
        check({tag, ".cpu_stall"},  32'(cpu_stall),  32'd0);
        check({tag, ".ram_we"},     32'(ram_we),     32'd0);
        check({tag, ".ram_adr"},    32'(ram_adr),    32'd0);
        check({tag, ".ram_wdata"},  ram_wdata,       32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h020] = 32'hAABBCCDD;

        rst_n      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 4'd0;
        cpu_adr    = '0;
        cpu_wdata  = 32'd0;
        host_req   = 1'b0;
        host_we    = 4'd0;
        host_adr   = '0;
        host_wdata = 32'd0;

        // Reset state
        tick();
        tick();
        settle();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        settle();
        check_reset_outputs("post_reset");

        // Host read of 0x010, uncontended: ack one cycle after the request
        tick();
        host_req = 1'b1;
        host_we  = 4'd0;
        host_adr = 12'h010;
        settle();
        check("hrd.ram_adr",   32'(ram_adr),   32'h010);
        check("hrd.ram_we",    32'(ram_we),    32'd0);
        check("hrd.ack_T",     32'(host_ack),  32'd0);
        check("hrd.stall_T",   32'(cpu_stall), 32'd0);
        tick();
        settle();
        check("hrd.ack_T1",    32'(host_ack),  32'd1);
        check("hrd.rdata",     host_rdata,     32'hDEADBEEF);
        check("hrd.stall_T1",  32'(cpu_stall), 32'd0);
        tick();
        host_req = 1'b0;
        settle();
        check("hrd.ack_T2",    32'(host_ack),  32'd0);
        check("hrd.adr_hold",  32'(ram_adr),   32'h010);
        check("hrd.we_idle",   32'(ram_we),    32'd0);

        // Host writes the low half of 0x020, then the CPU reads it back
        tick();
        host_req   = 1'b1;
        host_we    = 4'b0011;
        host_adr   = 12'h020;
        host_wdata = 32'h12345678;
        settle();
        check("hwr.ram_we",    32'(ram_we),    32'h3);
        check("hwr.ram_wdata", ram_wdata,      32'h12345678);
        tick();
        settle();
        check("hwr.ack",       32'(host_ack),  32'd1);
        tick();
        host_req = 1'b0;
        host_we  = 4'd0;
        cpu_req  = 1'b1;
        cpu_we   = 4'd0;
        cpu_adr  = 12'h020;
        settle();
        check("crd.stall",     32'(cpu_stall), 32'd0);
        check("crd.ram_adr",   32'(ram_adr),   32'h020);
        check("crd.ram_we",    32'(ram_we),    32'd0);
        tick();
        cpu_req = 1'b0;
        settle();
        check("crd.rdata",     cpu_rdata,      32'hAABB5678);

        // Contention: CPU holds the RAM while the host waits on 0x010
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 4'd0;
        cpu_adr  = 12'h030;
        host_req = 1'b1;
        host_we  = 4'd0;
        host_adr = 12'h010;
`ifdef DMEM_ARB_STARVE_EN
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("starve.stall_%0d", i), 32'(cpu_stall), 32'd0);
            check($sformatf("starve.ack_%0d", i),   32'(host_ack),  32'd0);
            check($sformatf("starve.adr_%0d", i),   32'(ram_adr),   32'h030);
            tick();
        end
        settle();
        check("starve.stall_8",  32'(cpu_stall), 32'd1);
        check("starve.adr_8",    32'(ram_adr),   32'h010);
        check("starve.ack_8",    32'(host_ack),  32'd0);
        tick();
        settle();
        check("starve.ack_9",    32'(host_ack),  32'd1);
        check("starve.rdata_9",  host_rdata,     32'hDEADBEEF);
        check("starve.stall_9",  32'(cpu_stall), 32'd0);
        check("starve.adr_9",    32'(ram_adr),   32'h030);
        tick();
        host_req = 1'b0;
        settle();
        check("starve.stall_10", 32'(cpu_stall), 32'd0);
        check("starve.ack_10",   32'(host_ack),  32'd0);
        tick();
        cpu_req = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            settle();
            check($sformatf("strict.stall_%0d", i), 32'(cpu_stall), 32'd0);
            check($sformatf("strict.ack_%0d", i),   32'(host_ack),  32'd0);
            check($sformatf("strict.adr_%0d", i),   32'(ram_adr),   32'h030);
            tick();
        end
        cpu_req = 1'b0;
        settle();
        check("strict.grant_adr", 32'(ram_adr),  32'h010);
        check("strict.ack_drop",  32'(host_ack), 32'd0);
        tick();
        settle();
        check("strict.ack",       32'(host_ack), 32'd1);
        check("strict.rdata",     host_rdata,    32'hDEADBEEF);
        tick();
        host_req = 1'b0;
        settle();
        check("strict.ack_after", 32'(host_ack), 32'd0);
`endif

        // Back-to-back host reads: request stays high after the first ack
        tick();
        host_req = 1'b1;
        host_we  = 4'd0;
        host_adr = 12'h010;
        settle();
        check("b2b.adr1",  32'(ram_adr),  32'h010);
        tick();
        settle();
        check("b2b.ack1",  32'(host_ack), 32'd1);
        check("b2b.data1", host_rdata,    32'hDEADBEEF);
        tick();
        host_adr = 12'h020;
        settle();
        check("b2b.adr2",  32'(ram_adr),  32'h020);
        check("b2b.gap",   32'(host_ack), 32'd0);
        tick();
        settle();
        check("b2b.ack2",  32'(host_ack), 32'd1);
        check("b2b.data2", host_rdata,    32'hAABB5678);
        tick();
        host_req = 1'b0;
        settle();
        check("b2b.end",   32'(host_ack), 32'd0);

        // Reset asserted in the ack cycle of a host write
        tick();
        host_req   = 1'b1;
        host_we    = 4'hF;
        host_adr   = 12'h040;
        host_wdata = 32'hCAFEF00D;
        settle();
        check("rst.we",  32'(ram_we),   32'hF);
        tick();
        rst_n    = 1'b0;
        host_req = 1'b0;
        host_we  = 4'd0;
        settle();
        check("rst.ack_in_reset", 32'(host_ack), 32'd1);
        tick();
        rst_n = 1'b1;
        settle();
        check_reset_outputs("rst_hack");

        // Host is eligible again straight away, and the write survived
        tick();
        host_req = 1'b1;
        host_adr = 12'h040;
        settle();
        check("rst.regrant_adr", 32'(ram_adr),  32'h040);
        tick();
        settle();
        check("rst.reack",       32'(host_ack), 32'd1);
        check("rst.kept_write",  host_rdata,    32'hCAFEF00D);
        tick();
        host_req = 1'b0;
        settle();
        check("rst.end", 32'(host_ack), 32'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
